// File: rtl/boot_mem_sequencer.sv
// -----------------------------------------------------------------------------
// boot_mem_sequencer
//
// Boot controller and owner of the single unified memory port of the
// multicycle RISC-V core. After reset the core is held in reset while a
// program is streamed from a word loader (UART/debug front end) into memory
// starting at BASE_ADDR. When the load finishes, core_rst stays high for
// another RST_HOLD cycles. The core is then released, and the memory port is
// handed to it as a zero-latency pass-through. A reload pulse in RUN re-enters
// load mode without a global reset.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   ld_valid/ld_data/ld_last/ld_ready
//                    loader word stream (valid/ready handshake)
//   reload           single-cycle request to reload, honoured only in RUN
//   core_rst         reset to the core (active high)
//   core_Adr/core_MemWrite/core_Data_out/core_Data_in
//                    core side of the memory port
//   mem_Adr/mem_WE/mem_WD/mem_RD
//                    memory side (combinational read data)
//   boot_done        high while the core owns the port (RUN)
//   word_count       words written in the current/last load
//   overrun          sticky: a loader word arrived while ld_ready was low
// -----------------------------------------------------------------------------
module boot_mem_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          PROG_WORDS = 64,
  parameter int          CNT_W      = 7,
  parameter int          RST_HOLD   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  input  logic [31:0]      ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  input  logic             reload,
  output logic             core_rst,
  input  logic [31:0]      core_Adr,
  input  logic             core_MemWrite,
  input  logic [31:0]      core_Data_out,
  output logic [31:0]      core_Data_in,
  output logic [31:0]      mem_Adr,
  output logic             mem_WE,
  output logic [31:0]      mem_WD,
  input  logic [31:0]      mem_RD,
  output logic             boot_done,
  output logic [CNT_W-1:0] word_count,
  output logic             overrun
);

  // The hold counter only has to reach RST_HOLD-1, but it keeps counting
  // once per HOLD cycle, so it is sized to hold RST_HOLD itself.
  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              accept;
  logic              last_word;
  logic              hold_done;
  logic [31:0]       load_adr;

  assign ld_ready     = (state == ST_LOAD);
  assign boot_done    = (state == ST_RUN);
  assign accept       = ld_valid & ld_ready;
  assign core_Data_in = mem_RD;

  // A load ends on an explicit ld_last or when the word cap is reached.
  // Because the cap moves the sequencer out of LOAD, word_count never
  // exceeds PROG_WORDS and never wraps.
  assign last_word = ld_last | (word_count == CNT_W'(PROG_WORDS - 1));
  assign hold_done = (hold_cnt == HOLD_W'(RST_HOLD - 1));

  // Word index to byte offset: append two zero bits.
  assign load_adr = BASE_ADDR + {{(30 - CNT_W){1'b0}}, word_count, 2'b00};

  // Memory port ownership. In RUN the core drives the port directly, so a
  // write issued in the same cycle as a reload still reaches memory.
  always_comb begin
    mem_Adr = 32'h0;
    mem_WE  = 1'b0;
    mem_WD  = 32'h0;
    case (state)
      ST_RUN: begin
        mem_Adr = core_Adr;
        mem_WE  = core_MemWrite;
        mem_WD  = core_Data_out;
      end
      ST_HOLD: begin
        mem_Adr = 32'h0;
        mem_WE  = 1'b0;
        mem_WD  = 32'h0;
      end
      default: begin
        mem_Adr = load_adr;
        mem_WE  = accept;
        mem_WD  = ld_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_LOAD;
      hold_cnt   <= '0;
      word_count <= '0;
      overrun    <= 1'b0;
      core_rst   <= 1'b1;
    end else begin
      // Outside LOAD any presented word is dropped and flagged.
      if (ld_valid && !ld_ready) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_LOAD: begin
          if (accept) begin
            word_count <= word_count + CNT_W'(1);
            if (last_word) begin
              state    <= ST_HOLD;
              hold_cnt <= '0;
            end
          end
        end
        ST_HOLD: begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
          // core_rst drops on the same edge that enters RUN.
          if (hold_done) begin
            state    <= ST_RUN;
            core_rst <= 1'b0;
          end
        end
        ST_RUN: begin
          if (reload) begin
            state      <= ST_LOAD;
            word_count <= '0;
            core_rst   <= 1'b1;
          end
        end
        default: begin
          state    <= ST_LOAD;
          core_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_mem_sequencer.sv
module tb_boot_mem_sequencer;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int PW = 4;
  localparam int CW = 3;
  localparam int RH = 4;

  logic          clk = 1'b0;
  logic          rst, ld_valid, ld_last, ld_ready, reload, core_rst;
  logic [31:0]   ld_data, core_Adr, core_Data_out, core_Data_in;
  logic          core_MemWrite, mem_WE, boot_done, overrun;
  logic [31:0]   mem_Adr, mem_WD, mem_RD;
  logic [CW-1:0] word_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  boot_mem_sequencer #(
    .BASE_ADDR(BASE), .PROG_WORDS(PW), .CNT_W(CW), .RST_HOLD(RH)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .reload(reload), .core_rst(core_rst),
    .core_Adr(core_Adr), .core_MemWrite(core_MemWrite),
    .core_Data_out(core_Data_out), .core_Data_in(core_Data_in),
    .mem_Adr(mem_Adr), .mem_WE(mem_WE), .mem_WD(mem_WD), .mem_RD(mem_RD),
    .boot_done(boot_done), .word_count(word_count), .overrun(overrun)
  );

  // Bench memory written through the DUT's memory port.
  logic [31:0] bram [0:15];
  logic        ram_clr = 1'b0;
  int          dut_wr = 0;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 16; i++) bram[i] <= 32'h0;
    end else if (mem_WE) begin
      bram[mem_Adr[5:2]] <= mem_WD;
      dut_wr <= dut_wr + 1;
    end
  end

  // Reference model: loading flag, remaining hold cycles, word count,
  // sticky overrun and the expected memory image.
  bit          m_loading = 1'b1;
  int          m_hold_left = 0;
  int          m_count = 0;
  bit          m_over = 1'b0;
  logic [31:0] m_ram [0:15];
  int          m_wr = 0;

  function automatic bit m_running();
    return (!m_loading && m_hold_left == 0);
  endfunction

  task automatic model_step();
    bit run_now;
    run_now = m_running();
    if (ram_clr) for (int i = 0; i < 16; i++) m_ram[i] = 32'h0;
    if (rst) begin
      m_loading = 1'b1; m_hold_left = 0; m_count = 0; m_over = 1'b0;
    end else begin
      if (!m_loading && ld_valid) m_over = 1'b1;
      if (run_now && core_MemWrite) begin
        m_ram[core_Adr[5:2]] = core_Data_out; m_wr++;
      end
      if (m_loading) begin
        if (ld_valid) begin
          m_ram[(BASE >> 2) + 32'(m_count)] = ld_data; m_wr++; m_count++;
          if (ld_last || m_count == PW) begin
            m_loading = 1'b0; m_hold_left = RH;
          end
        end
      end else if (m_hold_left > 0) begin
        m_hold_left--;
      end else if (reload) begin
        m_loading = 1'b1; m_count = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    ld_valid = 0; ld_last = 0; ld_data = 0; reload = 0;
    core_Adr = 0; core_MemWrite = 0; core_Data_out = 0;
  endtask

  task automatic test_reset();
    idle(); mem_RD = 0; rst = 1; ram_clr = 1;
    tick(); ram_clr = 0;
    tick(); rst = 0; #1;
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL reset_core_rst got=%0b exp=1", core_rst); end
    total++; if (boot_done !== 1'b0) begin bad++; $display("FAIL reset_boot_done got=%0b exp=0", boot_done); end
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL reset_ld_ready got=%0b exp=1", ld_ready); end
    total++; if (word_count !== 3'd0) begin bad++; $display("FAIL reset_word_count got=%0d exp=0", word_count); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    total++; if (mem_WE !== 1'b0) begin bad++; $display("FAIL reset_mem_WE got=%0b exp=0", mem_WE); end
  endtask

  task automatic test_basic_load();
    logic [31:0] w [3];
    int n;
    w[0] = 32'h0050_0093; w[1] = 32'h00A0_0113; w[2] = 32'h0020_81B3;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin idle(); tick(); end
      ld_valid = 1; ld_data = w[i]; ld_last = (i == 2); #1;
      total++; if (mem_WE !== 1'b1) begin bad++; $display("FAIL load_we[%0d] got=%0b exp=1", i, mem_WE); end
      total++; if (mem_Adr !== BASE + 32'(4*i)) begin bad++; $display("FAIL load_adr[%0d] got=%h exp=%h", i, mem_Adr, BASE + 32'(4*i)); end
      total++; if (mem_WD !== w[i]) begin bad++; $display("FAIL load_wd[%0d] got=%h exp=%h", i, mem_WD, w[i]); end
      tick();
    end
    idle(); #1;
    n = 0;
    while (!boot_done && n < 20) begin
      total++; if (core_rst !== 1'b1 || mem_WE !== 1'b0) begin bad++; $display("FAIL hold_outputs core_rst=%0b mem_WE=%0b exp 1/0", core_rst, mem_WE); end
      tick(); n++;
    end
    total++; if (n !== RH) begin bad++; $display("FAIL hold_cycles got=%0d exp=%0d", n, RH); end
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL run_core_rst got=%0b exp=0", core_rst); end
    total++; if (word_count !== 3'd3) begin bad++; $display("FAIL load_word_count got=%0d exp=3", word_count); end
    for (int i = 0; i < 3; i++) begin
      total++; if (bram[i] !== w[i]) begin bad++; $display("FAIL load_mem[%0d] got=%h exp=%h", i, bram[i], w[i]); end
    end
  endtask

  task automatic test_run_passthrough();
    core_Adr = 32'h10; core_MemWrite = 1; core_Data_out = 32'hDEADBEEF; mem_RD = 32'h1234; #1;
    total++; if (mem_Adr !== 32'h10) begin bad++; $display("FAIL pass_adr got=%h exp=10", mem_Adr); end
    total++; if (mem_WE !== 1'b1) begin bad++; $display("FAIL pass_we got=%0b exp=1", mem_WE); end
    total++; if (mem_WD !== 32'hDEADBEEF) begin bad++; $display("FAIL pass_wd got=%h exp=deadbeef", mem_WD); end
    total++; if (core_Data_in !== 32'h1234) begin bad++; $display("FAIL pass_rd got=%h exp=1234", core_Data_in); end
    tick(); idle(); #1;
    total++; if (mem_WE !== 1'b0) begin bad++; $display("FAIL pass_we_off got=%0b exp=0", mem_WE); end
    total++; if (bram[4] !== 32'hDEADBEEF) begin bad++; $display("FAIL pass_mem got=%h exp=deadbeef", bram[4]); end
  endtask

  task automatic test_cap();
    logic [31:0] d [6];
    rst = 1; ram_clr = 1; tick(); rst = 0; ram_clr = 0;
    for (int i = 0; i < 6; i++) begin
      d[i] = $urandom; ld_valid = 1; ld_data = d[i]; ld_last = 0; #1;
      total++; if (mem_WE !== (i < 4)) begin bad++; $display("FAIL cap_we[%0d] got=%0b exp=%0b", i, mem_WE, (i < 4)); end
      if (i < 4) begin
        total++; if (mem_Adr !== BASE + 32'(4*i)) begin bad++; $display("FAIL cap_adr[%0d] got=%h exp=%h", i, mem_Adr, BASE + 32'(4*i)); end
      end
      total++; if (overrun !== (i > 4)) begin bad++; $display("FAIL cap_overrun[%0d] got=%0b exp=%0b", i, overrun, (i > 4)); end
      tick();
    end
    idle(); #1;
    total++; if (word_count !== 3'd4) begin bad++; $display("FAIL cap_word_count got=%0d exp=4", word_count); end
    total++; if (bram[4] !== 32'h0) begin bad++; $display("FAIL cap_no_write_10 got=%h exp=0", bram[4]); end
    for (int i = 0; i < 4; i++) begin
      total++; if (bram[i] !== d[i]) begin bad++; $display("FAIL cap_mem[%0d] got=%h exp=%h", i, bram[i], d[i]); end
    end
    total++; if (dut_wr !== m_wr) begin bad++; $display("FAIL cap_write_count got=%0d exp=%0d", dut_wr, m_wr); end
  endtask

  task automatic test_reload();
    int n;
    n = 0;
    while (!boot_done && n < 20) begin tick(); n++; end
    total++; if (boot_done !== 1'b1) begin bad++; $display("FAIL reload_wait_run got=%0b exp=1", boot_done); end
    reload = 1; tick(); reload = 0; #1;
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL reload_core_rst got=%0b exp=1", core_rst); end
    total++; if (word_count !== 3'd0) begin bad++; $display("FAIL reload_word_count got=%0d exp=0", word_count); end
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL reload_ld_ready got=%0b exp=1", ld_ready); end
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1; ld_data = $urandom; ld_last = (i == 1); #1;
      total++; if (mem_WE !== 1'b1 || mem_Adr !== BASE + 32'(4*i)) begin bad++; $display("FAIL reload_write[%0d] we=%0b adr=%h exp 1/%h", i, mem_WE, mem_Adr, BASE + 32'(4*i)); end
      tick();
    end
    idle(); #1;
    n = 0;
    while (!boot_done && n < 20) begin tick(); n++; end
    total++; if (n !== RH) begin bad++; $display("FAIL reload_hold_cycles got=%0d exp=%0d", n, RH); end
    total++; if (word_count !== 3'd2) begin bad++; $display("FAIL reload_word_count_end got=%0d exp=2", word_count); end
  endtask

  task automatic test_reset_mid();
    reload = 1; tick(); reload = 0;
    for (int i = 0; i < 2; i++) begin ld_valid = 1; ld_data = $urandom; ld_last = 0; tick(); end
    idle(); rst = 1; tick(); rst = 0; #1;
    total++; if (word_count !== 3'd0 || core_rst !== 1'b1 || ld_ready !== 1'b1) begin bad++; $display("FAIL midload_reset wc=%0d core_rst=%0b ready=%0b exp 0/1/1", word_count, core_rst, ld_ready); end
    ld_valid = 1; ld_data = $urandom; #1;
    total++; if (mem_WE !== 1'b1 || mem_Adr !== BASE) begin bad++; $display("FAIL midload_first_adr we=%0b adr=%h exp 1/%h", mem_WE, mem_Adr, BASE); end
    tick();
    ld_last = 1; ld_data = $urandom; tick();
    idle(); tick(); tick();
    total++; if (ld_ready !== 1'b0 || core_rst !== 1'b1) begin bad++; $display("FAIL inhold ready=%0b core_rst=%0b exp 0/1", ld_ready, core_rst); end
    rst = 1; tick(); rst = 0; #1;
    total++; if (word_count !== 3'd0 || core_rst !== 1'b1 || ld_ready !== 1'b1 || boot_done !== 1'b0) begin bad++; $display("FAIL hold_reset wc=%0d core_rst=%0b ready=%0b done=%0b exp 0/1/1/0", word_count, core_rst, ld_ready, boot_done); end
    ld_valid = 1; ld_data = $urandom; ld_last = 1; #1;
    total++; if (mem_WE !== 1'b1 || mem_Adr !== BASE) begin bad++; $display("FAIL hold_reset_adr we=%0b adr=%h exp 1/%h", mem_WE, mem_Adr, BASE); end
    tick(); idle();
  endtask

  task automatic test_random();
    bit e_run, e_we;
    logic [31:0] e_adr, e_wd;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(99) == 0);
      ld_valid = !rst && ($urandom_range(2) == 0);
      ld_data = $urandom; ld_last = ($urandom_range(7) == 0);
      reload = ($urandom_range(15) == 0);
      core_Adr = 32'($urandom_range(15)) << 2;
      core_MemWrite = !rst && ($urandom_range(1) == 1);
      core_Data_out = $urandom; mem_RD = $urandom; #1;
      e_run = m_running();
      e_we = m_loading ? ld_valid : (e_run ? core_MemWrite : 1'b0);
      e_adr = m_loading ? BASE + 32'(4*m_count) : (e_run ? core_Adr : 32'h0);
      e_wd = m_loading ? ld_data : (e_run ? core_Data_out : 32'h0);
      total++; if (ld_ready !== m_loading) begin bad++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, ld_ready, m_loading); end
      total++; if (boot_done !== e_run || core_rst !== !e_run) begin bad++; $display("FAIL rnd_run c=%0d done=%0b core_rst=%0b exp_run=%0b", c, boot_done, core_rst, e_run); end
      total++; if (word_count !== CW'(m_count)) begin bad++; $display("FAIL rnd_word_count c=%0d got=%0d exp=%0d", c, word_count, m_count); end
      total++; if (overrun !== m_over) begin bad++; $display("FAIL rnd_overrun c=%0d got=%0b exp=%0b", c, overrun, m_over); end
      total++; if (mem_WE !== e_we) begin bad++; $display("FAIL rnd_we c=%0d got=%0b exp=%0b", c, mem_WE, e_we); end
      total++; if (mem_Adr !== e_adr) begin bad++; $display("FAIL rnd_adr c=%0d got=%h exp=%h", c, mem_Adr, e_adr); end
      if (e_we || !m_loading) begin
        total++; if (mem_WD !== e_wd) begin bad++; $display("FAIL rnd_wd c=%0d got=%h exp=%h", c, mem_WD, e_wd); end
      end
      total++; if (core_Data_in !== mem_RD) begin bad++; $display("FAIL rnd_rd c=%0d got=%h exp=%h", c, core_Data_in, mem_RD); end
      tick();
    end
    idle(); rst = 0; tick();
    for (int i = 0; i < 16; i++) begin
      total++; if (bram[i] !== m_ram[i]) begin bad++; $display("FAIL rnd_mem[%0d] got=%h exp=%h", i, bram[i], m_ram[i]); end
    end
    total++; if (dut_wr !== m_wr) begin bad++; $display("FAIL rnd_write_count got=%0d exp=%0d", dut_wr, m_wr); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_ram[i] = 32'h0;
    rst = 1; idle(); mem_RD = 0;
    test_reset();
    test_basic_load();
    test_run_passthrough();
    test_cap();
    test_reload();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/boot_mem_sequencer.md
Name: boot_mem_sequencer

Overview:
Boot controller and memory-port owner for the multicycle RISC-V core. After reset it holds the core in reset and streams a program from a word loader (UART/debug front end) into the unified instruction/data memory at BASE_ADDR. It then releases the core and hands the single memory port over to it. A reload request re-enters load mode without a global reset.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first program word (word aligned)
PROG_WORDS, 64, maximum words accepted per load (>=1)
CNT_W, 7, width of word counter; must hold PROG_WORDS
RST_HOLD, 4, cycles core_rst stays high after load completes (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
ld_valid  in  1  loader word valid
ld_data  in  32  loader word
ld_last  in  1  qualifies final word of program (valid with ld_valid)
ld_ready  out  1  sequencer can accept a word this cycle
reload  in  1  single-cycle request to reload (honoured only in RUN)
core_rst  out  1  reset to riscv_core (active high)
core_Adr  in  32  core memory address
core_MemWrite  in  1  core write enable
core_Data_out  in  32  core write data
core_Data_in  out  32  read data to core
mem_Adr  out  32  memory address
mem_WE  out  1  memory write enable
mem_WD  out  32  memory write data
mem_RD  in  32  memory read data (combinational read)
boot_done  out  1  high in RUN
word_count  out  CNT_W  words written in current/last load
overrun  out  1  sticky: ld_valid seen while ld_ready low

Behaviour:
- States: LOAD, HOLD, RUN; state, hold counter, word_count, overrun and core_rst are flops.
- Reset (rst=1 at edge, any state, including mid-load): state=LOAD, word_count=0, hold counter=0, overrun=0, core_rst=1. boot_done=0. ld_ready=1 from the first cycle after reset.
- LOAD: ld_ready=1 and core_rst=1.
  - Accept = ld_valid & ld_ready.
  - On accept, same cycle: mem_WE=1, mem_Adr=BASE_ADDR+4*word_count, mem_WD=ld_data. word_count increments at the edge.
  - No accept: mem_WE=0, mem_Adr=BASE_ADDR+4*word_count.
  - If the accepted word has ld_last=1, or word_count+1==PROG_WORDS: next state=HOLD and the hold counter loads 0.
  - ld_valid gaps are allowed; there is no timeout.
- HOLD: ld_ready=0, mem_WE=0, mem_Adr=0, mem_WD=0, core_rst=1. The hold counter increments each cycle. After RST_HOLD cycles in HOLD, next state=RUN.
  - Timing: last word accepted in cycle N gives HOLD in cycles N+1..N+RST_HOLD, RUN from N+RST_HOLD+1.
  - core_rst flop clears on the same edge as entry to RUN.
- RUN: core_rst=0, boot_done=1, ld_ready=0.
  - mem_Adr=core_Adr, mem_WE=core_MemWrite, mem_WD=core_Data_out; combinational pass-through, zero latency.
  - word_count holds its final value.
- core_Data_in=mem_RD in all states.
- reload=1 in RUN: at that edge state=LOAD, word_count=0, core_rst=1. Any core write in that same cycle still completes. reload in LOAD/HOLD is ignored.
- overrun: set on any edge where ld_valid=1 and ld_ready=0, in HOLD or RUN. Cleared only by rst. An ld_valid pulse in the RUN cycle where reload=1 also sets it.
- Words presented after the PROG_WORDS cap is reached are never written; they set overrun.
- word_count never wraps. Maximum is PROG_WORDS.

Test Plan:
- Reset check: rst high for 2 cycles -> core_rst=1, boot_done=0, ld_ready=1, word_count=0, overrun=0, mem_WE=0.
- Basic load: 3 words 0x00500093, 0x00A00113, 0x002081B3, ld_last on the third, 1-cycle gap before the second -> writes at 0x0, 0x4, 0x8. RUN follows exactly RST_HOLD=4 cycles after the last accept; boot_done=1; word_count=3.
- RUN pass-through: core_Adr=0x10, core_MemWrite=1, core_Data_out=0xDEADBEEF -> same cycle mem_Adr=0x10, mem_WE=1, mem_WD=0xDEADBEEF; mem_RD=0x1234 -> core_Data_in=0x1234.
- Cap with PROG_WORDS=4 and no ld_last, 6 words streamed back-to-back -> only 4 writes (0x0–0xC), word_count=4, overrun=1 on the 5th word, no write at 0x10.
- Reload: in RUN pulse reload, then load 2 words with ld_last -> core_rst=1 the cycle after reload, word_count restarts at 0, writes at 0x0 and 0x4, RUN again after 4 hold cycles.
- Reset mid-operation: rst asserted after the 2nd word of a load and again during HOLD -> state returns to LOAD, word_count=0, core_rst stays 1, the next accepted word is written to BASE_ADDR.
